// File: rtl/alu_share_pkg.sv
// alu_share_pkg: opcodes, result constants and helpers shared by alu_share_arbiter
package alu_share_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_OR  = 4'd2,
        ALU_SLL = 4'd3
    } alu_op_e;
    localparam logic [31:0] ALU_BAD_RESULT = 32'hFFFFFFFF;
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && !(&v)) ? v + 16'd1 : v;
    endfunction
endpackage

// File: rtl/alu.sv
// alu: 32-bit combinational ALU (add, sub, or, shift-left) with equality and parity flags
// Ports: a, b operands; shamt shift amount; aluop opcode; c result; equal a==b; oddone ^a
module alu
    import alu_share_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  logic [3:0]  aluop,
    output logic [31:0] c,
    output logic        equal,
    output logic        oddone
);
    always_comb begin
        c = aluop == ALU_ADD ? a + b :
            aluop == ALU_SUB ? a - b :
            aluop == ALU_OR  ? a | b :
            aluop == ALU_SLL ? b << shamt : ALU_BAD_RESULT;
        equal  = a == b;
        oddone = ^a;
    end
endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; a tie goes to the requester that did not win last
// Ports: clk, reset (async, active-low); elig request mask; gnt one-hot or zero; last_gnt last winner id
module rr_arb2
    import alu_share_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] elig,
    output logic [1:0] gnt,
    output logic       last_gnt
);
    always_comb begin
        gnt[0] = elig[0] & (~elig[1] | (last_gnt == REQ1));
        gnt[1] = elig[1] & (~elig[0] | (last_gnt == REQ0));
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_gnt <= REQ1;
        else if (|gnt)
            last_gnt <= gnt[1] ? REQ1 : REQ0;
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two valid/ready requesters with one-entry response slots
// Ports: clk; reset (async, active-low); reqN_* request channel (valid/ready, a, b, shamt, aluop);
//        rspN_* response slot (valid/ready, c, equal, oddone).
// Build option: define ALU_SHARE_ARBITER_STATS_EN to add saturating 16-bit counters
//        stat_gnt0, stat_gnt1 (grants) and stat_conflict (cycles with both requests valid).
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [4:0]       req0_shamt,
    input  logic [OPW-1:0]   req0_aluop,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_c,
    output logic             rsp0_equal,
    output logic             rsp0_oddone,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [4:0]       req1_shamt,
    input  logic [OPW-1:0]   req1_aluop,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_c,
    output logic             rsp1_equal,
    output logic             rsp1_oddone
`ifdef ALU_SHARE_ARBITER_STATS_EN
    ,
    output logic [15:0]      stat_gnt0,
    output logic [15:0]      stat_gnt1,
    output logic [15:0]      stat_conflict
`endif
);
    logic [1:0]       elig;
    logic [1:0]       gnt;
    logic             last_gnt;
    logic             sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_shamt;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_c;
    logic             alu_equal;
    logic             alu_oddone;

    // A slot accepts a new op when empty or draining this cycle; holding reset masks all grants.
    assign elig = {req1_valid & (~rsp1_valid | rsp1_ready),
                   req0_valid & (~rsp0_valid | rsp0_ready)} & {2{reset}};

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .elig     (elig),
        .gnt      (gnt),
        .last_gnt (last_gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Idle cycles park the operand mux on the last winner to avoid needless toggling.
    always_comb begin
        sel       = gnt[1] | (~gnt[0] & last_gnt);
        alu_a     = sel == REQ1 ? req1_a     : req0_a;
        alu_b     = sel == REQ1 ? req1_b     : req0_b;
        alu_shamt = sel == REQ1 ? req1_shamt : req0_shamt;
        alu_op    = sel == REQ1 ? req1_aluop : req0_aluop;
    end

    alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .shamt  (alu_shamt),
        .aluop  (alu_op),
        .c      (alu_c),
        .equal  (alu_equal),
        .oddone (alu_oddone)
    );

    // A grant reloads its slot even while it drains, giving one op per cycle per requester.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp0_valid  <= 1'b0;
            rsp0_c      <= '0;
            rsp0_equal  <= 1'b0;
            rsp0_oddone <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_c      <= '0;
            rsp1_equal  <= 1'b0;
            rsp1_oddone <= 1'b0;
        end else begin
            rsp0_valid <= gnt[0] | (rsp0_valid & ~rsp0_ready);
            rsp1_valid <= gnt[1] | (rsp1_valid & ~rsp1_ready);
            if (gnt[0]) begin
                rsp0_c      <= alu_c;
                rsp0_equal  <= alu_equal;
                rsp0_oddone <= alu_oddone;
            end
            if (gnt[1]) begin
                rsp1_c      <= alu_c;
                rsp1_equal  <= alu_equal;
                rsp1_oddone <= alu_oddone;
            end
        end
    end

`ifdef ALU_SHARE_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_gnt0     <= '0;
            stat_gnt1     <= '0;
            stat_conflict <= '0;
        end else begin
            stat_gnt0     <= sat_inc(stat_gnt0, gnt[0]);
            stat_gnt1     <= sat_inc(stat_gnt1, gnt[1]);
            stat_conflict <= sat_inc(stat_conflict, req0_valid & req1_valid);
        end
    end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: vector table, directed corner cases and random traffic against a reference model
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_equal, rsp0_oddone;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_equal, rsp1_oddone;
    logic [31:0] req0_a, req0_b, rsp0_c, req1_a, req1_b, rsp1_c;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [3:0]  req0_aluop, req1_aluop;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_shamt  (req0_shamt),
        .req0_aluop  (req0_aluop),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_c      (rsp0_c),
        .rsp0_equal  (rsp0_equal),
        .rsp0_oddone (rsp0_oddone),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_shamt  (req1_shamt),
        .req1_aluop  (req1_aluop),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_c      (rsp1_c),
        .rsp1_equal  (rsp1_equal),
        .rsp1_oddone (rsp1_oddone)
`ifdef ALU_SHARE_ARBITER_STATS_EN
        ,
        .stat_gnt0     (stat_gnt0),
        .stat_gnt1     (stat_gnt1),
        .stat_conflict (stat_conflict)
`endif
    );

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        rr;
    } req_t;

    typedef struct {
        logic        rst;
        req_t        r0;
        req_t        r1;
        logic        rdy0, rdy1;
        logic        val0, eq0, odd0;
        logic [31:0] c0;
        logic        val1, eq1, odd1;
        logic [31:0] c1;
    } vec_t;

    // reference model: slot contents per requester and the id of the last winner
    bit          mv[2];
    logic [31:0] mc[2];
    bit          meq[2];
    bit          modd[2];
    int          mlast;

    function automatic req_t rq(input logic v, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] sh, input logic rr);
        req_t r;
        r.v = v; r.op = op; r.a = a; r.b = b; r.sh = sh; r.rr = rr;
        return r;
    endfunction

    function automatic vec_t row(input logic rst, input req_t r0, input req_t r1,
                                 input logic rdy0, input logic rdy1,
                                 input logic val0, input logic [31:0] c0, input logic eq0, input logic odd0,
                                 input logic val1, input logic [31:0] c1, input logic eq1, input logic odd1);
        vec_t t;
        t.rst = rst; t.r0 = r0; t.r1 = r1; t.rdy0 = rdy0; t.rdy1 = rdy1;
        t.val0 = val0; t.c0 = c0; t.eq0 = eq0; t.odd0 = odd0;
        t.val1 = val1; t.c1 = c1; t.eq1 = eq1; t.odd1 = odd1;
        return t;
    endfunction

    function automatic logic [31:0] ref_c(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a | b;
            4'd3:    return b << sh;
            default: return 32'hFFFFFFFF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input req_t r0, input req_t r1);
        req0_valid = r0.v; req0_aluop = r0.op; req0_a = r0.a; req0_b = r0.b;
        req0_shamt = r0.sh; rsp0_ready = r0.rr;
        req1_valid = r1.v; req1_aluop = r1.op; req1_a = r1.a; req1_b = r1.b;
        req1_shamt = r1.sh; rsp1_ready = r1.rr;
    endtask

    task automatic model_reset();
        mv = '{0, 0};
        mc = '{32'd0, 32'd0};
        meq = '{0, 0};
        modd = '{0, 0};
        mlast = 1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        drive(rq(0, 0, 0, 0, 0, 0), rq(0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        #2 reset = 1'b1;
        model_reset();
    endtask

    task automatic do_cycle(input req_t r0, input req_t r1, output logic s0, output logic s1);
        req_t r[2];
        bit   e[2];
        int   win;
        r[0] = r0;
        r[1] = r1;
        @(negedge clk);
        drive(r0, r1);
        for (int i = 0; i < 2; i++) e[i] = r[i].v && (!mv[i] || r[i].rr);
        win = (e[0] && e[1]) ? 1 - mlast : e[0] ? 0 : e[1] ? 1 : -1;
        #1;
        s0 = req0_ready;
        s1 = req1_ready;
        chk("ready0", {31'd0, s0}, {31'd0, win == 0});
        chk("ready1", {31'd0, s1}, {31'd0, win == 1});
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (win == i) begin
                mv[i] = 1;
                mc[i] = ref_c(r[i].op, r[i].a, r[i].b, r[i].sh);
                meq[i] = r[i].a == r[i].b;
                modd[i] = ($countones(r[i].a) % 2) == 1;
            end else if (r[i].rr) begin
                mv[i] = 0;
            end
        end
        if (win >= 0) mlast = win;
        chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, mv[0]});
        chk("rsp0_c", rsp0_c, mc[0]);
        chk("rsp0_equal", {31'd0, rsp0_equal}, {31'd0, meq[0]});
        chk("rsp0_oddone", {31'd0, rsp0_oddone}, {31'd0, modd[0]});
        chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, mv[1]});
        chk("rsp1_c", rsp1_c, mc[1]);
        chk("rsp1_equal", {31'd0, rsp1_equal}, {31'd0, meq[1]});
        chk("rsp1_oddone", {31'd0, rsp1_oddone}, {31'd0, modd[1]});
    endtask

    initial begin
        vec_t tbl[$];
        req_t idle, sub0, or1;
        logic s0, s1;
        idle = rq(0, 0, 0, 0, 0, 0);
        sub0 = rq(1, 4'd1, 32'd3, 32'd5, 5'd0, 1);
        or1  = rq(1, 4'd2, 32'hF0, 32'h0F, 5'd0, 1);

        tbl.push_back(row(1, rq(1, 4'd0, 32'd5, 32'd7, 5'd0, 1), rq(0, 0, 0, 0, 0, 1),
                          1, 0, 1, 32'd12, 0, 0, 0, 32'd0, 0, 0));
        tbl.push_back(row(1, sub0, or1, 1, 0, 1, 32'hFFFFFFFE, 0, 0, 0, 32'd0, 0, 0));
        tbl.push_back(row(0, sub0, or1, 0, 1, 0, 32'hFFFFFFFE, 0, 0, 1, 32'hFF, 0, 0));
        tbl.push_back(row(0, sub0, or1, 1, 0, 1, 32'hFFFFFFFE, 0, 0, 0, 32'hFF, 0, 0));
        tbl.push_back(row(0, sub0, or1, 0, 1, 0, 32'hFFFFFFFE, 0, 0, 1, 32'hFF, 0, 0));
        tbl.push_back(row(0, rq(1, 4'd1, 32'd3, 32'd5, 5'd0, 0), or1,
                          1, 0, 1, 32'hFFFFFFFE, 0, 0, 0, 32'hFF, 0, 0));
        tbl.push_back(row(0, rq(1, 4'd1, 32'd3, 32'd5, 5'd0, 0), or1,
                          0, 1, 1, 32'hFFFFFFFE, 0, 0, 1, 32'hFF, 0, 0));
        tbl.push_back(row(0, rq(1, 4'd1, 32'd3, 32'd5, 5'd0, 0), rq(1, 4'd3, 32'd0, 32'd1, 5'd31, 1),
                          0, 1, 1, 32'hFFFFFFFE, 0, 0, 1, 32'h80000000, 0, 0));
        tbl.push_back(row(0, sub0, rq(1, 4'hF, 32'd3, 32'd3, 5'd0, 1),
                          1, 0, 1, 32'hFFFFFFFE, 0, 0, 0, 32'h80000000, 0, 0));
        tbl.push_back(row(0, sub0, rq(1, 4'hF, 32'd3, 32'd3, 5'd0, 1),
                          0, 1, 0, 32'hFFFFFFFE, 0, 0, 1, 32'hFFFFFFFF, 1, 0));
        tbl.push_back(row(0, rq(1, 4'd0, 32'd1, 32'd0, 5'd0, 1), rq(0, 0, 0, 0, 0, 0),
                          1, 0, 1, 32'd1, 0, 1, 1, 32'hFFFFFFFF, 1, 0));

        // reset state, with requests already valid while reset is held
        drive(sub0, or1);
        model_reset();
        #12;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_rsp0_c", rsp0_c, 32'd0);
        chk("rst_rsp1_c", rsp1_c, 32'd0);
        chk("rst_flags", {28'd0, rsp0_equal, rsp0_oddone, rsp1_equal, rsp1_oddone}, 32'd0);
        pulse_reset();

        foreach (tbl[k]) begin
            if (tbl[k].rst) pulse_reset();
            do_cycle(tbl[k].r0, tbl[k].r1, s0, s1);
            chk($sformatf("tbl%0d_rdy", k), {30'd0, s1, s0}, {30'd0, tbl[k].rdy1, tbl[k].rdy0});
            chk($sformatf("tbl%0d_c0", k), rsp0_c, tbl[k].c0);
            chk($sformatf("tbl%0d_c1", k), rsp1_c, tbl[k].c1);
            chk($sformatf("tbl%0d_flags", k),
                {26'd0, rsp0_valid, rsp0_equal, rsp0_oddone, rsp1_valid, rsp1_equal, rsp1_oddone},
                {26'd0, tbl[k].val0, tbl[k].eq0, tbl[k].odd0, tbl[k].val1, tbl[k].eq1, tbl[k].odd1});
        end

        // asynchronous reset in the middle of a cycle while slot 1 holds a result
        pulse_reset();
        do_cycle(idle, rq(1, 4'd2, 32'hF0, 32'h0F, 5'd0, 0), s0, s1);
        chk("mid_pre_valid1", {31'd0, rsp1_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("mid_rsp1_c", rsp1_c, 32'd0);
        chk("mid_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        drive(idle, idle);
        #1 reset = 1'b1;
        model_reset();
        do_cycle(sub0, or1, s0, s1);
        chk("mid_first_tie", {30'd0, s1, s0}, 32'd1);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            req_t r[2];
            for (int i = 0; i < 2; i++) begin
                r[i].v = 1'($urandom_range(0, 3) != 0);
                r[i].op = 4'($urandom_range(0, 5));
                r[i].a = $urandom;
                r[i].b = ($urandom_range(0, 3) == 0) ? r[i].a : $urandom;
                r[i].sh = 5'($urandom_range(0, 31));
                r[i].rr = 1'($urandom_range(0, 2) != 0);
            end
            do_cycle(r[0], r[1], s0, s1);
        end

`ifdef ALU_SHARE_ARBITER_STATS_EN
        pulse_reset();
        repeat (3) do_cycle(sub0, or1, s0, s1);
        chk("stat_gnt0", {16'd0, stat_gnt0}, 32'd2);
        chk("stat_gnt1", {16'd0, stat_gnt1}, 32'd1);
        chk("stat_conflict", {16'd0, stat_conflict}, 32'd3);
        @(negedge clk);
        drive(sub0, idle);
        repeat (65540) @(posedge clk);
        #1;
        chk("stat_gnt0_sat", {16'd0, stat_gnt0}, 32'hFFFF);
        chk("stat_conflict_hold", {16'd0, stat_conflict}, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
